// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle req/ack clock-domain crossing.
package cdc_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // Bits needed to hold values 0..value-1 (value >= 2 gives at least 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; the first flop may go metastable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source-domain end of a two-phase (toggle) req/ack crossing for multi-bit words.
// A word accepted on din_valid_i/din_ready_o is parked on dout_o, req_o flips, and
// the sender waits until the synchronized ack level matches req_o again.
// Optional feature macro: CDC_HS_TIMEOUT_EN adds a sticky timeout_err_o after
// TIMEOUT cycles in WAIT_ACK; without it timeout_err_o is tied low.
module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              req_o,
  input  logic              ack_i,
  output logic              sent_o,
  output logic              timeout_err_o
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("DATA_W must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("STAGES must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              sent_q, sent_d;
  logic              ack_s;
  logic              xfer;

  // Raw ack is asynchronous; only the synchronized copy is ever used.
  sync_ff_chain #(.STAGES(STAGES)) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  assign din_ready_o = (state_q == ST_IDLE);
  assign xfer        = din_valid_i & din_ready_o;

  // Next-state logic: launch a word from IDLE, complete when ack level catches up with req.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dout_d  = dout_q;
    sent_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // An ack toggle seen here is a protocol error and is deliberately ignored.
        if (din_valid_i) begin
          dout_d  = din_i;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = ST_IDLE;
          sent_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request level and held data bus; reset aborts any word in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      dout_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      sent_q  <= sent_d;
    end
  end

  assign req_o  = req_q;
  assign dout_o = dout_q;
  assign sent_o = sent_q;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int               CNT_W   = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Count WAIT_ACK cycles from zero on each launch; saturate and latch the error at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ST_IDLE) begin
      if (xfer) begin
        cnt_d = '0;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err_o = err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Scoreboard bench for cdc_handshake_sender (DATA_W=8, STAGES=2, TIMEOUT=16).
module tb_cdc_handshake_sender;

  localparam int DATA_W  = 8;
  localparam int STAGES  = 2;
  localparam int TIMEOUT = 16;
  localparam int ACK_DLY = 3;
`ifdef CDC_HS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_i;
  logic [DATA_W-1:0] din_i;
  logic              din_valid_i;
  logic              din_ready_o;
  logic [DATA_W-1:0] dout_o;
  logic              req_o;
  logic              ack_i;
  logic              sent_o;
  logic              timeout_err_o;

  cdc_handshake_sender #(
    .DATA_W  (DATA_W),
    .STAGES  (STAGES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .din_i         (din_i),
    .din_valid_i   (din_valid_i),
    .din_ready_o   (din_ready_o),
    .dout_o        (dout_o),
    .req_o         (req_o),
    .ack_i         (ack_i),
    .sent_o        (sent_o),
    .timeout_err_o (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_chk  = 0;
  int                n_pass = 0;
  int                n_sent = 0;
  logic [DATA_W-1:0] sb[$];
  bit                exp_req = 1'b0;
  bit                auto_ack = 1'b0;
  bit                was_wait = 1'b0;
  logic [DATA_W-1:0] held_dout = '0;
  bit                held_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Push accepted words and track the request level the DUT should hold.
  always @(posedge clk) begin
    if (rst_i) begin
      exp_req <= 1'b0;
    end else if (din_valid_i && din_ready_o) begin
      sb.push_back(din_i);
      exp_req <= ~exp_req;
    end
  end

  // Pop and compare on each sent pulse; check the bus holds while waiting.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (sent_o) begin
        n_sent++;
        if (sb.size() == 0) check("sent_unexpected", 32'(sent_o), 32'(0));
        else check("sent_word", 32'(dout_o), 32'(sb.pop_front()));
      end
      if (was_wait && !din_ready_o) begin
        check("dout_stable", 32'(dout_o), 32'(held_dout));
        check("req_stable", 32'(req_o), 32'(held_req));
      end
      was_wait  <= !din_ready_o;
      held_dout <= dout_o;
      held_req  <= req_o;
    end else begin
      was_wait <= 1'b0;
    end
  end

  // Destination-side model: echo req onto ack ACK_DLY cycles after it changes.
  initial begin : ack_echo
    forever begin
      @(posedge clk);
      if (auto_ack && !rst_i && ack_i != req_o) begin
        repeat (ACK_DLY - 1) @(posedge clk);
        #1;
        if (auto_ack) ack_i = req_o;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input int n);
    rst_i       = 1'b1;
    din_valid_i = 1'b0;
    ack_i       = 1'b0;
    sb.delete();
    repeat (n) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int maxc);
    bit done;
    done        = 1'b0;
    din_i       = w;
    din_valid_i = 1'b1;
    for (int k = 0; k < maxc && !done; k++) begin
      @(posedge clk);
      if (din_ready_o) done = 1'b1;
    end
    #1;
    check("xfer_accept", 32'(done), 32'(1));
  endtask

  task automatic wait_sent(input int maxc, output int lat);
    lat = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sent_o) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int n0;

  initial begin : stim
    rst_i = 1'b1; din_i = '0; din_valid_i = 1'b0; ack_i = 1'b0;

    // Reset state
    do_reset(3);
    @(negedge clk);
    check("rst_ready", 32'(din_ready_o), 32'(1));
    check("rst_req", 32'(req_o), 32'(0));
    check("rst_dout", 32'(dout_o), 32'(0));
    check("rst_sent", 32'(sent_o), 32'(0));
    check("rst_err", 32'(timeout_err_o), 32'(0));

    // Single word, ack driven by hand
    send_word(8'hA5, 4);
    din_valid_i = 1'b0;
    @(negedge clk);
    check("t2_dout", 32'(dout_o), 32'(8'hA5));
    check("t2_req", 32'(req_o), 32'(1));
    check("t2_ready", 32'(din_ready_o), 32'(0));
    repeat (4) @(posedge clk);
    #1 ack_i = 1'b1;
    wait_sent(10, lat);
    check("t2_latency", 32'(lat), 32'(STAGES + 1));
    @(posedge clk); @(negedge clk);
    check("t2_sent_1cyc", 32'(sent_o), 32'(0));
    check("t2_ready_back", 32'(din_ready_o), 32'(1));

    // Streaming words 1..4 with echoed ack
    auto_ack = 1'b1;
    n0 = n_sent;
    for (int w = 1; w <= 4; w++) send_word(8'(w), 40);
    din_valid_i = 1'b0;
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t3_sb_empty", 32'(sb.size()), 32'(0));
    check("t3_sent_count", 32'(n_sent - n0), 32'(4));
    auto_ack = 1'b0;

    // Spurious ack toggle while idle
    @(posedge clk);
    #1 ack_i = ~ack_i;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_idle_ready", 32'(din_ready_o), 32'(1));
      check("t4_idle_req", 32'(req_o), 32'(exp_req));
      check("t4_idle_sent", 32'(sent_o), 32'(0));
    end
    send_word(8'h3C, 4);
    din_valid_i = 1'b0;
    wait_sent(10, lat);
    check("t4_fast_complete", 32'(lat), 32'(1));
    send_word(8'h96, 4);
    din_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_hold_no_sent", 32'(sent_o), 32'(0));
    end
    @(posedge clk);
    #1 ack_i = ~ack_i;
    wait_sent(10, lat);
    check("t4_latency", 32'(lat), 32'(STAGES + 1));

    // Reset while waiting for ack
    send_word(8'h77, 4);
    din_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    ack_i = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("t5_req", 32'(req_o), 32'(0));
    check("t5_dout", 32'(dout_o), 32'(0));
    check("t5_ready", 32'(din_ready_o), 32'(1));
    check("t5_sent", 32'(sent_o), 32'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_no_sent", 32'(sent_o), 32'(0));
    end
    auto_ack = 1'b1;
    send_word(8'hC3, 4);
    din_valid_i = 1'b0;
    wait_sent(20, lat);
    check("t5_after_reset", 32'(lat), 32'(ACK_DLY + STAGES + 1));
    repeat (3) @(negedge clk);
    auto_ack = 1'b0;

    // Timeout with no ack, then a late ack
    send_word(8'h5A, 4);
    din_valid_i = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == TIMEOUT) check("t6_err_before", 32'(timeout_err_o), 32'(0));
      if (i == TIMEOUT + 1) check("t6_err_rise", 32'(timeout_err_o), 32'(TO_EN));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_err_sticky", 32'(timeout_err_o), 32'(TO_EN));
      check("t6_still_wait", 32'(din_ready_o), 32'(0));
    end
    @(posedge clk);
    #1 ack_i = ~ack_i;
    wait_sent(10, lat);
    check("t6_late_ack", 32'(lat), 32'(STAGES + 1));
    @(negedge clk);
    check("t6_err_kept", 32'(timeout_err_o), 32'(TO_EN));
    check("t6_ready", 32'(din_ready_o), 32'(1));
    check("t6_sb_empty", 32'(sb.size()), 32'(0));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
